// File: rtl/f_bpred_npc_if.sv
`default_nettype none
// ============================================================================
// Module   : f_bpred_npc_if
// Brief    : F-stage fetch / D-stage resolve signals of the predicting NPC unit
// Revision : 1.0
// ============================================================================
interface f_bpred_npc_if;
    logic        stall;
    logic [31:0] F_PC;
    logic [31:0] F_pred_next;
    logic        F_pred_taken;
    logic        D_valid;
    logic [31:0] D_PC;
    logic [31:0] D_pred_next;
    logic [2:0]  D_NPCop;
    logic        D_need_b;
    logic [25:0] D_imm26;
    logic [31:0] D_rs_data;
    logic        D_flush;

    // Pipeline side: hazard unit and F/D register
    modport master (
        output stall, D_valid, D_PC, D_pred_next, D_NPCop, D_need_b, D_imm26, D_rs_data,
        input  F_PC, F_pred_next, F_pred_taken, D_flush
    );

    // Next-PC unit side
    modport slave (
        input  stall, D_valid, D_PC, D_pred_next, D_NPCop, D_need_b, D_imm26, D_rs_data,
        output F_PC, F_pred_next, F_pred_taken, D_flush
    );
endinterface
`default_nettype wire

// File: rtl/f_bpred_npc.sv
`default_nettype none
// ============================================================================
// Module   : f_bpred_npc
// Brief    : F-stage PC register with direct-mapped BTB prediction, D-stage resolve
// Revision : 1.0
// ============================================================================
module f_bpred_npc #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned IDX_W    = 4
) (
    input  wire logic    clk,
    input  wire logic    reset,
    f_bpred_npc_if.slave bus
);
    localparam int unsigned c_entries = 1 << IDX_W;
    localparam int unsigned c_tag_w   = 32 - IDX_W - 2;
    localparam logic [2:0]  c_op_br   = 3'd1;
    localparam logic [2:0]  c_op_j    = 3'd2;
    localparam logic [2:0]  c_op_jr   = 3'd3;

    logic [31:0]          r_pc;
    logic [c_entries-1:0] r_btb_valid;
    logic [c_entries-1:0] r_btb_uncond;
    logic [c_tag_w-1:0]   r_btb_tag    [c_entries];
    logic [31:0]          r_btb_target [c_entries];
    logic [1:0]           r_btb_cnt    [c_entries];

    // F-side lookup
    logic [IDX_W-1:0]   w_f_idx;
    logic [c_tag_w-1:0] w_f_tag;
    logic               w_f_hit;
    logic               w_f_taken;
    logic [31:0]        w_f_next;

    assign w_f_idx   = r_pc[IDX_W+1:2];
    assign w_f_tag   = r_pc[31:IDX_W+2];
    assign w_f_hit   = r_btb_valid[w_f_idx] && (r_btb_tag[w_f_idx] == w_f_tag);
    assign w_f_taken = w_f_hit && (r_btb_uncond[w_f_idx] || r_btb_cnt[w_f_idx][1]);
    assign w_f_next  = w_f_taken ? r_btb_target[w_f_idx] : (r_pc + 32'd4);

    // D-side resolve, same target arithmetic as the combinational NPC
    logic [31:0] w_d_seq;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic [31:0] w_actual_next;
    logic        w_res;
    logic        w_mispredict;

    assign w_d_seq     = bus.D_PC + 32'd4;
    assign w_br_target = w_d_seq + {{14{bus.D_imm26[15]}}, bus.D_imm26[15:0], 2'b00};
    assign w_j_target  = {bus.D_PC[31:28], bus.D_imm26, 2'b00};

    always_comb begin
        w_actual_next = w_d_seq;
        case (bus.D_NPCop)
            c_op_br: if (bus.D_need_b) w_actual_next = w_br_target;
            c_op_j:  w_actual_next = w_j_target;
            c_op_jr: w_actual_next = bus.D_rs_data;
            default: w_actual_next = w_d_seq;
        endcase
    end

    assign w_res        = bus.D_valid && !bus.stall;
    assign w_mispredict = w_res && (w_actual_next != bus.D_pred_next);

    // D-side BTB read port and write-data selection
    logic [IDX_W-1:0]   w_d_idx;
    logic [c_tag_w-1:0] w_d_tag;
    logic               w_d_hit;
    logic               w_wr_en;
    logic [31:0]        w_wr_target;
    logic [1:0]         w_wr_cnt;
    logic               w_wr_uncond;

    assign w_d_idx = bus.D_PC[IDX_W+1:2];
    assign w_d_tag = bus.D_PC[31:IDX_W+2];
    assign w_d_hit = r_btb_valid[w_d_idx] && (r_btb_tag[w_d_idx] == w_d_tag);

    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_target = r_btb_target[w_d_idx];
        w_wr_cnt    = r_btb_cnt[w_d_idx];
        w_wr_uncond = r_btb_uncond[w_d_idx];
        if (w_res) begin
            case (bus.D_NPCop)
                c_op_br: begin
                    if (w_d_hit) begin
                        w_wr_en = 1'b1;
                        if (bus.D_need_b) begin
                            w_wr_target = w_br_target;
                            if (r_btb_cnt[w_d_idx] != 2'b11) w_wr_cnt = r_btb_cnt[w_d_idx] + 2'd1;
                        end else if (r_btb_cnt[w_d_idx] != 2'b00) begin
                            w_wr_cnt = r_btb_cnt[w_d_idx] - 2'd1;
                        end
                    end else if (bus.D_need_b) begin
                        w_wr_en     = 1'b1;
                        w_wr_target = w_br_target;
                        w_wr_cnt    = 2'b10;
                        w_wr_uncond = 1'b0;
                    end
                end
                c_op_j: begin
                    w_wr_en     = 1'b1;
                    w_wr_target = w_j_target;
                    w_wr_cnt    = 2'b11;
                    w_wr_uncond = 1'b1;
                end
                default: w_wr_en = 1'b0;
            endcase
        end
    end

    // Reset outranks a pending redirect; only valid bits need clearing
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc        <= RESET_PC;
            r_btb_valid <= '0;
        end else begin
            if (w_mispredict) begin
                r_pc <= w_actual_next;
            end else if (!bus.stall) begin
                r_pc <= w_f_next;
            end
            if (w_wr_en) begin
                r_btb_valid[w_d_idx]  <= 1'b1;
                r_btb_uncond[w_d_idx] <= w_wr_uncond;
                r_btb_tag[w_d_idx]    <= w_d_tag;
                r_btb_target[w_d_idx] <= w_wr_target;
                r_btb_cnt[w_d_idx]    <= w_wr_cnt;
            end
        end
    end

    assign bus.F_PC         = r_pc;
    assign bus.F_pred_next  = w_f_next;
    assign bus.F_pred_taken = w_f_taken;
    assign bus.D_flush      = w_mispredict;
endmodule
`default_nettype wire

// File: tb/tb_f_bpred_npc.sv
`default_nettype none
// ============================================================================
// Module   : tb_f_bpred_npc
// Brief    : Randomized pipeline-driven bench for f_bpred_npc with a reference model
// Revision : 1.0
// ============================================================================
module tb_f_bpred_npc;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int          IDX_W    = 4;
    localparam int          NENT     = 1 << IDX_W;

    logic clk = 1'b0;
    logic reset;

    f_bpred_npc_if bus ();

    f_bpred_npc #(.RESET_PC(RESET_PC), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model: BTB keyed by index, each entry remembers the full word address it belongs to
    typedef struct {
        bit        valid;
        bit [29:0] word;
        bit [31:0] target;
        int        ctr;
        bit        uncond;
    } entry_t;

    entry_t    m_btb [NENT];
    bit [31:0] m_pc;

    // F/D register kept by the bench acting as the pipeline
    bit        fd_valid = 1'b0;
    bit [31:0] fd_pc    = '0;
    bit [31:0] fd_pred  = '0;

    bit [2:0]  prog_op  [64];
    bit [25:0] prog_imm [64];

    function automatic int idx_of(input bit [31:0] pc);
        return int'((pc >> 2) % NENT);
    endfunction

    function automatic bit m_hit(input bit [31:0] pc);
        int i = idx_of(pc);
        return m_btb[i].valid && (m_btb[i].word == pc[31:2]);
    endfunction

    task automatic m_predict(input bit [31:0] pc, output bit taken, output bit [31:0] nxt);
        int i = idx_of(pc);
        taken = m_hit(pc) && (m_btb[i].uncond || m_btb[i].ctr >= 2);
        nxt   = taken ? m_btb[i].target : pc + 32'd4;
    endtask

    function automatic bit [31:0] m_actual(input bit [31:0] pc, input bit [2:0] op, input bit nb,
                                           input bit [25:0] imm, input bit [31:0] rs);
        bit [15:0] lo  = imm[15:0];
        int        off = int'($signed(lo));
        case (op)
            3'd1:    return nb ? pc + 32'd4 + 32'(off * 4) : pc + 32'd4;
            3'd2:    return {pc[31:28], imm, 2'b00};
            3'd3:    return rs;
            default: return pc + 32'd4;
        endcase
    endfunction

    task automatic m_update(input bit [31:0] pc, input bit [2:0] op, input bit nb, input bit [31:0] act);
        int i = idx_of(pc);
        if (op == 3'd1) begin
            if (m_hit(pc)) begin
                if (nb) begin
                    m_btb[i].ctr    = (m_btb[i].ctr < 3) ? m_btb[i].ctr + 1 : 3;
                    m_btb[i].target = act;
                end else begin
                    m_btb[i].ctr = (m_btb[i].ctr > 0) ? m_btb[i].ctr - 1 : 0;
                end
            end else if (nb) begin
                m_btb[i] = '{valid: 1'b1, word: pc[31:2], target: act, ctr: 2, uncond: 1'b0};
            end
        end else if (op == 3'd2) begin
            m_btb[i] = '{valid: 1'b1, word: pc[31:2], target: act, ctr: 3, uncond: 1'b1};
        end
    endtask

    task automatic m_reset();
        m_pc     = RESET_PC;
        fd_valid = 1'b0;
        for (int i = 0; i < NENT; i++) m_btb[i].valid = 1'b0;
    endtask

    // One clock: drive at edge+1, compare at negedge, advance the model, return to edge+1
    task automatic cycle(input bit rst_n, input bit stl, input bit dv, input bit [31:0] dpc,
                         input bit [31:0] dpred, input bit [2:0] op, input bit nb,
                         input bit [25:0] imm, input bit [31:0] rs);
        bit        ptk;
        bit [31:0] pnx;
        bit [31:0] act;
        bit [31:0] old_pc;
        bit        res;
        bit        misp;
        reset           = rst_n;
        bus.stall       = stl;
        bus.D_valid     = dv;
        bus.D_PC        = dpc;
        bus.D_pred_next = dpred;
        bus.D_NPCop     = op;
        bus.D_need_b    = nb;
        bus.D_imm26     = imm;
        bus.D_rs_data   = rs;
        @(negedge clk);
        m_predict(m_pc, ptk, pnx);
        act  = m_actual(dpc, op, nb, imm, rs);
        res  = dv && !stl;
        misp = res && (act != dpred);
        check("F_PC", bus.F_PC, m_pc);
        check("F_pred_next", bus.F_pred_next, pnx);
        check("F_pred_taken", 32'(bus.F_pred_taken), 32'(ptk));
        if (rst_n) check("D_flush", 32'(bus.D_flush), 32'(misp));
        old_pc = m_pc;
        if (!rst_n) begin
            m_reset();
        end else begin
            if (res) m_update(dpc, op, nb, act);
            if (misp) begin
                m_pc     = act;
                fd_valid = 1'b0;
            end else if (!stl) begin
                m_pc     = pnx;
                fd_valid = 1'b1;
                fd_pc    = old_pc;
                fd_pred  = pnx;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Decode the D instruction from the random program occupying 0x3000..0x30FC
    task automatic prog_cycle(input bit rst_n, input bit stl);
        bit [2:0]  op  = 3'd0;
        bit [25:0] imm = 26'($urandom);
        bit [31:0] rs  = $urandom;
        bit        nb  = ($urandom_range(0, 2) != 0);
        if (fd_pc >= RESET_PC && fd_pc < RESET_PC + 32'd256) begin
            op  = prog_op[int'((fd_pc - RESET_PC) >> 2)];
            imm = prog_imm[int'((fd_pc - RESET_PC) >> 2)];
        end
        if (op == 3'd3) rs = RESET_PC + 32'(4 * $urandom_range(0, 63));
        cycle(rst_n, stl, fd_valid, fd_pc, fd_pred, op, nb, imm, rs);
    endtask

    initial begin
        for (int w = 0; w < 64; w++) begin
            int r = int'($urandom_range(0, 9));
            int t = int'($urandom_range(0, 63));
            if (r < 5) begin
                prog_op[w]  = (r == 4) ? 3'($urandom_range(4, 7)) : 3'd0;
                prog_imm[w] = 26'($urandom);
            end else if (r < 7) begin
                prog_op[w]  = 3'd1;
                prog_imm[w] = {10'($urandom), 16'(t - w - 1)};
            end else if (r < 8) begin
                prog_op[w]  = 3'd2;
                prog_imm[w] = 26'(32'h0C00 + 32'(t));
            end else begin
                prog_op[w]  = 3'd3;
                prog_imm[w] = 26'($urandom);
            end
        end
        prog_op[63]  = 3'd2;
        prog_imm[63] = 26'h0000C00;

        // Free-run before reset, then a single reset cycle
        reset           = 1'b1;
        bus.stall       = 1'b0;
        bus.D_valid     = 1'b0;
        bus.D_PC        = '0;
        bus.D_pred_next = '0;
        bus.D_NPCop     = 3'd0;
        bus.D_need_b    = 1'b0;
        bus.D_imm26     = '0;
        bus.D_rs_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        m_reset();
        @(negedge clk);
        check("rst_F_PC", bus.F_PC, 32'h0000_3000);
        check("rst_pred_next", bus.F_pred_next, 32'h0000_3004);
        check("rst_pred_taken", 32'(bus.F_pred_taken), 32'd0);
        check("rst_flush", 32'(bus.D_flush), 32'd0);
        @(posedge clk);
        #1;
        m_pc = RESET_PC + 32'd4;

        for (int c = 0; c < 3000; c++) begin
            prog_cycle($urandom_range(0, 299) != 0, $urandom_range(0, 4) == 0);
        end

        // Branch at the top of the address space wraps its target to 0x4
        cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, RESET_PC, 3'd1, 1'b1, 26'h0000001, 32'd0);
        check("wrap_F_PC", bus.F_PC, 32'h0000_0004);

        for (int c = 0; c < 600; c++) begin
            bit [31:0] dpc  = $urandom & 32'hFFFF_FFFC;
            bit [2:0]  op   = 3'($urandom_range(0, 7));
            bit        nb   = 1'($urandom);
            bit [25:0] imm  = 26'($urandom);
            bit [31:0] rs   = $urandom;
            bit [31:0] pred = ($urandom_range(0, 1) == 0) ? m_actual(dpc, op, nb, imm, rs) : $urandom;
            cycle($urandom_range(0, 199) != 0, $urandom_range(0, 3) == 0, 1'($urandom), dpc, pred,
                  op, nb, imm, rs);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
